// File: rtl/memshare_pkg.sv
// Shared types and constants for the memshare shift scheduler.
// Holds the grant FSM state encoding and the requestor index-width helper.
package memshare_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    localparam int DEF_SHARE_GROUP_SIZE = 5;

    // A group of one requestor still needs a one-bit index.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_IDX_W = idx_w(DEF_SHARE_GROUP_SIZE);

endpackage

// File: rtl/memshare_flag_fifo.sv
// Synchronous FIFO that holds request-flag vectors waiting for the grant FSM.
// DEPTH must be a power of two so the pointers wrap naturally.
module memshare_flag_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             sys_clk,
    input  logic             rstn,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic [CW-1:0]    o_count,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    // Fullness is judged on the registered count, so a same-cycle pop never frees a slot.
    assign w_push = i_push && (r_count != CW'(DEPTH));
    assign w_pop  = i_pop && (r_count != '0);

    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (w_push) r_mem[r_wptr] <= i_din;
    end

    assign o_dout  = r_mem[r_rptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/memshare_shift_sched.sv
// Turns queued multi-hot request vectors into one register-file write per set bit,
// lowest index first, with back-to-back vector hand-over and a sticky overflow flag.
module memshare_shift_sched
    import memshare_pkg::*;
#(
    parameter int SHARE_GROUP_SIZE = DEF_SHARE_GROUP_SIZE,
    parameter int FIFO_DEPTH       = 4,
    parameter int RF_DEPTH         = 8,
    localparam int IDX_W           = idx_w(SHARE_GROUP_SIZE),
    localparam int RF_AW           = $clog2(RF_DEPTH),
    localparam int CNT_W           = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                        sys_clk,
    input  logic                        rstn,
    input  logic [SHARE_GROUP_SIZE-1:0] share_rqstFlag_i,
    input  logic                        rqst_valid_i,
    output logic                        rqst_ready_o,
    output logic                        rf_we_o,
    output logic [RF_AW-1:0]            rf_waddr_o,
    output logic [IDX_W-1:0]            rf_wdata_o,
    output logic                        rf_wlast_o,
    input  logic                        rf_full_i,
    output logic                        overflow_o,
    output logic [CNT_W-1:0]            fifo_count_o,
    output state_e                      dbg_state_o
);

    state_e                      r_state;
    state_e                      w_state_nxt;
    logic [SHARE_GROUP_SIZE-1:0] r_work;
    logic [SHARE_GROUP_SIZE-1:0] w_work_nxt;
    logic [RF_AW-1:0]            r_waddr;
    logic                        r_overflow;

    logic                        w_flag_nz;
    logic                        w_push;
    logic                        w_pop;
    logic [SHARE_GROUP_SIZE-1:0] w_head;
    logic [CNT_W-1:0]            w_count;
    logic                        w_empty;
    logic [IDX_W-1:0]            w_idx;
    logic                        w_last;
    logic                        w_we;
    logic                        w_wlast;
    logic [IDX_W-1:0]            w_wdata;

    assign w_flag_nz    = |share_rqstFlag_i;
    assign rqst_ready_o = (w_count < CNT_W'(FIFO_DEPTH));
    assign w_push       = rqst_valid_i && rqst_ready_o && w_flag_nz;

    memshare_flag_fifo #(
        .WIDTH (SHARE_GROUP_SIZE),
        .DEPTH (FIFO_DEPTH)
    ) u_flag_fifo (
        .sys_clk (sys_clk),
        .rstn    (rstn),
        .i_push  (w_push),
        .i_din   (share_rqstFlag_i),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_count (w_count),
        .o_empty (w_empty)
    );

    // Lowest set bit wins: scan from the top so the last hit is the smallest index.
    always_comb begin
        w_idx = '0;
        for (int i = SHARE_GROUP_SIZE - 1; i >= 0; i--) begin
            if (r_work[i]) w_idx = IDX_W'(i);
        end
    end

    assign w_last = (r_work != '0) && ((r_work & (r_work - 1'b1)) == '0);

    always_comb begin
        w_state_nxt = r_state;
        w_work_nxt  = r_work;
        w_pop       = 1'b0;
        w_we        = 1'b0;
        w_wlast     = 1'b0;
        w_wdata     = '0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_work_nxt  = w_head;
                    w_state_nxt = GRANT;
                end
            end
            GRANT: begin
                w_wdata = w_idx;
                // rstn gating keeps a mid-vector reset from writing in its own cycle.
                w_wlast = w_last && rstn;
                w_we    = !rf_full_i && rstn;
                if (w_we) begin
                    w_work_nxt = r_work & ~(SHARE_GROUP_SIZE'(1) << w_idx);
                    if (w_last) begin
                        if (!w_empty) begin
                            w_pop      = 1'b1;
                            w_work_nxt = w_head;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            r_state    <= IDLE;
            r_work     <= '0;
            r_waddr    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_work  <= w_work_nxt;
            if (w_we) r_waddr <= r_waddr + 1'b1;
            if (rqst_valid_i && !rqst_ready_o && w_flag_nz) r_overflow <= 1'b1;
        end
    end

    assign rf_we_o      = w_we;
    assign rf_wlast_o   = w_wlast;
    assign rf_wdata_o   = w_wdata;
    assign rf_waddr_o   = r_waddr;
    assign overflow_o   = r_overflow;
    assign fifo_count_o = w_count;
    assign dbg_state_o  = r_state;

endmodule
